// File: rtl/z2_bus_fsm_pkg.sv
// Shared Zorro II bus-cycle state encoding, used by autoconfig, RAM and IDE blocks.
package z2_bus_fsm_pkg;

  localparam logic [1:0] Z2_IDLE  = 2'd0;
  localparam logic [1:0] Z2_START = 2'd1;
  localparam logic [1:0] Z2_DATA  = 2'd2;
  localparam logic [1:0] Z2_END   = 2'd3;

  localparam int WAIT_W = 3;

endpackage

// File: rtl/z2_sync.sv
// Reset-to-1 multi-flop synchroniser for the asynchronous active-low 68000 bus strobes.
module z2_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr <= '1;
    else          sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/z2_bus_fsm.sv
// Zorro II slave bus-cycle sequencer: IDLE/START/DATA/END, DTACK and data-buffer control.
// Optional IDE wait states are enabled by defining Z2_IDE_WAIT_EN.
module z2_bus_fsm
  import z2_bus_fsm_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int IDE_WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic       rw,
  input  logic       board_sel,
  input  logic       ide_sel,
  output logic [1:0] z2_state,
  output logic       dtack_oe,
  output logic       data_oe,
  output logic       wr_strobe,
  output logic       claimed
);

  if (SYNC_STAGES < 2 || IDE_WAIT_CYCLES < 0 || IDE_WAIT_CYCLES > 7) begin : g_param_check
    $error("z2_bus_fsm: SYNC_STAGES or IDE_WAIT_CYCLES out of range");
  end

  logic as_s;
  logic uds_s;
  logic lds_s;
  logic ds_s;
  logic rw_l;

  z2_sync #(.STAGES(SYNC_STAGES)) u_sync_as  (.clk(clk), .reset_n(reset_n), .d(as_n),  .q(as_s));
  z2_sync #(.STAGES(SYNC_STAGES)) u_sync_uds (.clk(clk), .reset_n(reset_n), .d(uds_n), .q(uds_s));
  z2_sync #(.STAGES(SYNC_STAGES)) u_sync_lds (.clk(clk), .reset_n(reset_n), .d(lds_n), .q(lds_s));

  // Low when either strobe is asserted.
  assign ds_s = uds_s & lds_s;

`ifdef Z2_IDE_WAIT_EN
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(IDE_WAIT_CYCLES);
  logic              ide_l;
  logic [WAIT_W-1:0] wait_cnt;
`else
  logic ide_sel_unused;
  assign ide_sel_unused = ide_sel;
`endif

  // Every exit to IDLE (normal end or abort) clears all bus drivers on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z2_state  <= Z2_IDLE;
      rw_l      <= 1'b0;
      claimed   <= 1'b0;
      dtack_oe  <= 1'b0;
      data_oe   <= 1'b0;
      wr_strobe <= 1'b0;
`ifdef Z2_IDE_WAIT_EN
      ide_l     <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      case (z2_state)
        Z2_IDLE: begin
          if (!as_s) z2_state <= Z2_START;
        end
        Z2_START: begin
          rw_l    <= rw;
          claimed <= board_sel;
`ifdef Z2_IDE_WAIT_EN
          ide_l   <= ide_sel;
`endif
          if (as_s) begin
            z2_state <= Z2_IDLE;
            claimed  <= 1'b0;
          end else if (!board_sel) begin
            z2_state <= Z2_END;
          end else if (rw || !ds_s) begin
            z2_state  <= Z2_DATA;
            wr_strobe <= !rw;
            data_oe   <= rw;
`ifdef Z2_IDE_WAIT_EN
            wait_cnt  <= ide_sel ? WAIT_LOAD : '0;
`endif
          end
        end
        Z2_DATA: begin
          if (as_s) begin
            z2_state <= Z2_IDLE;
            claimed  <= 1'b0;
            data_oe  <= 1'b0;
`ifdef Z2_IDE_WAIT_EN
          end else if (ide_l && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
`endif
          end else begin
            z2_state <= Z2_END;
            dtack_oe <= claimed;
            data_oe  <= claimed & rw_l;
          end
        end
        default: begin
          if (as_s) begin
            z2_state <= Z2_IDLE;
            claimed  <= 1'b0;
            dtack_oe <= 1'b0;
            data_oe  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z2_bus_fsm.sv
// Directed bench for z2_bus_fsm: per-bus-cycle scoreboard plus point checks on outputs.
module tb_z2_bus_fsm;
  import z2_bus_fsm_pkg::*;

  localparam int IDE_WAIT = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       as_n, uds_n, lds_n, rw, board_sel, ide_sel;
  logic [1:0] z2_state;
  logic       dtack_oe, data_oe, wr_strobe, claimed;

  typedef struct packed {
    logic [3:0] data_clks;
    logic [3:0] wr_pulses;
    logic       dtack_seen;
    logic       doe_seen;
    logic       reached_end;
    logic       dtack_outside_end;
  } cyc_t;

  cyc_t sb[$];
  cyc_t mon;
  logic mon_en = 1'b0;
  logic [1:0] prev_state = Z2_IDLE;
  int   pass_cnt = 0, fail_cnt = 0, total = 0, done_cnt = 0;

  z2_bus_fsm #(.SYNC_STAGES(2), .IDE_WAIT_CYCLES(IDE_WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
    .board_sel(board_sel), .ide_sel(ide_sel), .z2_state(z2_state), .dtack_oe(dtack_oe),
    .data_oe(data_oe), .wr_strobe(wr_strobe), .claimed(claimed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t exp_cycle(input int dclks, input int wr, input logic dt, input logic doe,
                                     input logic ended);
    cyc_t c;
    c.data_clks         = 4'(dclks);
    c.wr_pulses         = 4'(wr);
    c.dtack_seen        = dt;
    c.doe_seen          = doe;
    c.reached_end       = ended;
    c.dtack_outside_end = 1'b0;
    return c;
  endfunction

  task automatic wait_state(input logic [1:0] s, input int max, input string tag);
    int n = 0;
    while (z2_state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(z2_state), 32'(s));
  endtask

  task automatic apply_stimulus(input logic rw_v, input logic sel_v, input logic ide_v, input logic ds_v);
    rw = rw_v; board_sel = sel_v; ide_sel = ide_v;
    uds_n = ds_v; lds_n = 1'b1;
    as_n = 1'b0;
  endtask

  task automatic release_bus();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
  endtask

  // Summarise each bus cycle when the FSM returns to IDLE and score it.
  always @(negedge clk) begin
    if (z2_state != Z2_IDLE) begin
      if (z2_state == Z2_DATA) mon.data_clks = mon.data_clks + 4'd1;
      if (wr_strobe) mon.wr_pulses = mon.wr_pulses + 4'd1;
      if (dtack_oe) mon.dtack_seen = 1'b1;
      if (data_oe) mon.doe_seen = 1'b1;
      if (z2_state == Z2_END) mon.reached_end = 1'b1;
    end
    if (dtack_oe && z2_state != Z2_END) mon.dtack_outside_end = 1'b1;
    if (prev_state != Z2_IDLE && z2_state == Z2_IDLE) begin
      if (mon_en) begin
        done_cnt++;
        if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
        else check("cycle", 32'(mon), 32'(sb.pop_front()));
      end
      mon = '0;
    end
    prev_state = z2_state;
  end

  initial begin
    mon = '0;
    reset_n = 1'b0;
    release_bus();
    rw = 1'b1; board_sel = 1'b0; ide_sel = 1'b0;
    #1;
    check("rst_state", 32'(z2_state), 32'(Z2_IDLE));
    check("rst_dtack", 32'(dtack_oe), 32'd0);
    check("rst_doe", 32'(data_oe), 32'd0);
    check("rst_wr", 32'(wr_strobe), 32'd0);
    check("rst_claimed", 32'(claimed), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold", 32'(z2_state), 32'(Z2_IDLE));

    $display("[TB] claimed read");
    sb.push_back(exp_cycle(1, 0, 1'b1, 1'b1, 1'b1));
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("read_sync_latency", 32'(z2_state), 32'(Z2_IDLE));
    wait_state(Z2_START, 4, "read_start");
    wait_state(Z2_END, 4, "read_end");
    check("read_end_dtack", 32'(dtack_oe), 32'd1);
    check("read_end_doe", 32'(data_oe), 32'd1);
    check("read_claimed", 32'(claimed), 32'd1);
    release_bus();
    wait_state(Z2_IDLE, 6, "read_idle");
    check("read_idle_outs", 32'({dtack_oe, data_oe, wr_strobe, claimed}), 32'd0);

    $display("[TB] write with late strobe");
    sb.push_back(exp_cycle(1, 1, 1'b1, 1'b0, 1'b1));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("write_hold_start", 32'(z2_state), 32'(Z2_START));
    check("write_no_strobe", 32'(wr_strobe), 32'd0);
    uds_n = 1'b0;
    wait_state(Z2_DATA, 5, "write_data");
    check("write_strobe", 32'(wr_strobe), 32'd1);
    wait_state(Z2_END, 4, "write_end");
    check("write_end_dtack", 32'(dtack_oe), 32'd1);
    check("write_end_doe", 32'(data_oe), 32'd0);
    release_bus();
    wait_state(Z2_IDLE, 6, "write_idle");

    $display("[TB] unclaimed cycle");
    sb.push_back(exp_cycle(0, 0, 1'b0, 1'b0, 1'b1));
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    wait_state(Z2_END, 6, "unclaimed_end");
    check("unclaimed_claimed", 32'(claimed), 32'd0);
    board_sel = 1'b1;
    @(negedge clk);
    check("unclaimed_decode_ignored", 32'(claimed), 32'd0);
    release_bus();
    wait_state(Z2_IDLE, 6, "unclaimed_idle");

    $display("[TB] IDE read");
`ifdef Z2_IDE_WAIT_EN
    sb.push_back(exp_cycle(1 + IDE_WAIT, 0, 1'b1, 1'b1, 1'b1));
`else
    sb.push_back(exp_cycle(1, 0, 1'b1, 1'b1, 1'b1));
`endif
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    wait_state(Z2_END, 12, "ide_end");
    release_bus();
    wait_state(Z2_IDLE, 6, "ide_idle");
    ide_sel = 1'b0;

    $display("[TB] abort in START");
    sb.push_back(exp_cycle(0, 0, 1'b0, 1'b0, 1'b0));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
    wait_state(Z2_START, 6, "abort_start");
    release_bus();
    wait_state(Z2_IDLE, 4, "abort_idle");
    check("abort_dtack", 32'(dtack_oe), 32'd0);

    $display("[TB] back-to-back reads");
    sb.push_back(exp_cycle(1, 0, 1'b1, 1'b1, 1'b1));
    sb.push_back(exp_cycle(1, 0, 1'b1, 1'b1, 1'b1));
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_state(Z2_END, 8, "b2b_end1");
    as_n = 1'b1;
    @(negedge clk);
    as_n = 1'b0;
    wait_state(Z2_IDLE, 6, "b2b_gap");
    wait_state(Z2_START, 4, "b2b_start2");
    wait_state(Z2_END, 6, "b2b_end2");
    check("b2b_dtack2", 32'(dtack_oe), 32'd1);
    release_bus();
    wait_state(Z2_IDLE, 6, "b2b_idle");

    $display("[TB] reset during END");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_state(Z2_END, 8, "rstmid_end");
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_dtack", 32'(dtack_oe), 32'd0);
    check("rstmid_doe", 32'(data_oe), 32'd0);
    check("rstmid_state", 32'(z2_state), 32'(Z2_IDLE));
    release_bus();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("cycles_scored", 32'(done_cnt), 32'd7);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
